// File: rtl/pipe_elastic_reg_pkg.sv
// Shared definitions for the elastic pipeline stage register.
// Holds default geometry, the per-cycle operation encoding and a pointer
// width helper that works for any DEPTH, including non powers of two.
package pipe_elastic_reg_pkg;

  localparam int PIPE_DEFAULT_DEPTH     = 2;
  localparam int PIPE_DEFAULT_PAYLOAD_W = 32;

  // What the queue does on a given edge, from the {push, pop} pair.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } op_e;

  // Pointer width; a single-entry queue still needs a 1-bit pointer.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic op_e op_kind(input logic push, input logic pop);
    return op_e'({push, pop});
  endfunction

endpackage

// File: rtl/pipe_elastic_reg_if.sv
// valid/ready/data handshake bundle used on both sides of the stage.
// master sources valid/data, slave returns ready.
interface pipe_elastic_reg_if #(
  parameter int PAYLOAD_W = 32
);
  logic                 valid;
  logic                 ready;
  logic [PAYLOAD_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_elastic_mem.sv
// Payload storage for the elastic stage: DEPTH x PAYLOAD_W registers,
// one write port, asynchronous read. Entries carry no reset; the parent
// forces its output to zero when the queue is empty.
module pipe_elastic_mem
  import pipe_elastic_reg_pkg::*;
#(
  parameter int PAYLOAD_W = PIPE_DEFAULT_PAYLOAD_W,
  parameter int DEPTH     = PIPE_DEFAULT_DEPTH
) (
  input  logic                          clk,
  input  logic                          wr_en,
  input  logic [ptr_width(DEPTH)-1:0]   wr_ptr,
  input  logic [PAYLOAD_W-1:0]          wr_data,
  input  logic [ptr_width(DEPTH)-1:0]   rd_ptr,
  output logic [PAYLOAD_W-1:0]          rd_data
);
  localparam int PTR_W = ptr_width(DEPTH);

  logic [DEPTH-1:0][PAYLOAD_W-1:0] entry_flat;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_entry
    logic [PAYLOAD_W-1:0] entry_reg;

    // Capture the payload when this slot is the write target.
    always_ff @(posedge clk) begin
      if (wr_en && (wr_ptr == PTR_W'(gi))) begin
        entry_reg <= wr_data;
      end
    end

    assign entry_flat[gi] = entry_reg;
  end

  assign rd_data = entry_flat[rd_ptr];

endmodule

// File: rtl/pipe_elastic_reg.sv
// Elastic pipeline stage register: DEPTH-entry circular queue between two
// valid/ready handshakes, with flush for mispredict squash. in_ready is a
// registered function of occupancy, so there is no combinational ready path.
// Optional feature macro: PIPE_STATS_EN adds a saturating stall counter.
module pipe_elastic_reg
  import pipe_elastic_reg_pkg::*;
#(
  parameter int PAYLOAD_W = PIPE_DEFAULT_PAYLOAD_W,
`ifdef PIPE_STATS_EN
  parameter int CNT_W     = 32,
`endif
  parameter int DEPTH     = PIPE_DEFAULT_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  pipe_elastic_reg_if.slave             up,
  pipe_elastic_reg_if.master            dn,
`ifdef PIPE_STATS_EN
  output logic [CNT_W-1:0]              stall_cnt,
`endif
  output logic [$clog2(DEPTH+1)-1:0]    count
);
  localparam int              PTR_W     = ptr_width(DEPTH);
  localparam int              OCC_W     = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0]     rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [OCC_W-1:0]     count_reg, count_next;
  logic                 in_ready_reg, in_ready_next;
  logic                 head_valid;
  logic                 push, pop;
  op_e                  op;
  logic [PAYLOAD_W-1:0] head_data;

  assign head_valid = (count_reg != '0);
  assign push       = up.valid && in_ready_reg && !flush;
  assign pop        = head_valid && dn.ready && !flush;
  assign op         = op_kind(push, pop);

  // Pointer/occupancy next state; flush empties the queue outright.
  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (op == OP_PUSH || op == OP_BOTH) begin
        wr_ptr_next = (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PTR_W'(1);
      end
      if (op == OP_POP || op == OP_BOTH) begin
        rd_ptr_next = (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PTR_W'(1);
      end
      case (op)
        OP_PUSH: count_next = count_reg + OCC_W'(1);
        OP_POP:  count_next = count_reg - OCC_W'(1);
        default: count_next = count_reg;
      endcase
    end
    in_ready_next = (count_next < DEPTH_OCC);
  end

  // State register; reset outranks flush, which is folded into *_next.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      in_ready_reg <= 1'b1;
    end else begin
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
      count_reg    <= count_next;
      in_ready_reg <= in_ready_next;
    end
  end

  pipe_elastic_mem #(
    .PAYLOAD_W (PAYLOAD_W),
    .DEPTH     (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_ptr  (wr_ptr_reg),
    .wr_data (up.data),
    .rd_ptr  (rd_ptr_reg),
    .rd_data (head_data)
  );

  assign up.ready = in_ready_reg;
  assign dn.valid = head_valid;
  assign dn.data  = head_valid ? head_data : '0;
  assign count    = count_reg;

`ifdef PIPE_STATS_EN
  logic [CNT_W-1:0] stall_reg;

  // Count cycles where the head waits on downstream; flush does not clear it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_reg <= '0;
    end else if (head_valid && !dn.ready && (stall_reg != '1)) begin
      stall_reg <= stall_reg + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_reg;
`endif

endmodule

// File: tb/tb_pipe_elastic_reg.sv
// Bench for pipe_elastic_reg: DEPTH=2 and DEPTH=3 instances share stimulus,
// each tracked by a queue model; directed phases pin literal values, then
// a randomized phase runs against the models.
module tb_pipe_elastic_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_elastic_reg_if #(.PAYLOAD_W(32)) up2 ();
  pipe_elastic_reg_if #(.PAYLOAD_W(32)) dn2 ();
  pipe_elastic_reg_if #(.PAYLOAD_W(32)) up3 ();
  pipe_elastic_reg_if #(.PAYLOAD_W(32)) dn3 ();

  assign up2.valid = in_valid;
  assign up2.data  = in_data;
  assign dn2.ready = out_ready;
  assign up3.valid = in_valid;
  assign up3.data  = in_data;
  assign dn3.ready = out_ready;

  logic [1:0] count2, count3;
`ifdef PIPE_STATS_EN
  logic [3:0] stall2, stall3;
`endif

  pipe_elastic_reg #(
    .PAYLOAD_W (32),
`ifdef PIPE_STATS_EN
    .CNT_W     (4),
`endif
    .DEPTH     (2)
  ) dut2 (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .up        (up2),
    .dn        (dn2),
`ifdef PIPE_STATS_EN
    .stall_cnt (stall2),
`endif
    .count     (count2)
  );

  pipe_elastic_reg #(
    .PAYLOAD_W (32),
`ifdef PIPE_STATS_EN
    .CNT_W     (4),
`endif
    .DEPTH     (3)
  ) dut3 (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .up        (up3),
    .dn        (dn3),
`ifdef PIPE_STATS_EN
    .stall_cnt (stall3),
`endif
    .count     (count3)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: plain FIFO queues plus stall counters.
  logic [31:0] q2[$];
  logic [31:0] q3[$];
  int st2 = 0;
  int st3 = 0;
  bit model_ok = 0;

  always @(posedge clk) begin
    bit pop2, push2, pop3, push3;
    if (rst) begin
      q2.delete();
      q3.delete();
      st2 = 0;
      st3 = 0;
      model_ok = 1;
    end else begin
      if (q2.size() != 0 && !out_ready && st2 != 15) st2++;
      if (q3.size() != 0 && !out_ready && st3 != 15) st3++;
      if (flush) begin
        q2.delete();
        q3.delete();
      end else begin
        pop2  = (q2.size() != 0) && out_ready;
        push2 = in_valid && (q2.size() < 2);
        pop3  = (q3.size() != 0) && out_ready;
        push3 = in_valid && (q3.size() < 3);
        if (pop2) void'(q2.pop_front());
        if (push2) q2.push_back(in_data);
        if (pop3) void'(q3.pop_front());
        if (push3) q3.push_back(in_data);
      end
    end
  end

  // Compare every cycle once reset has been seen.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("d2_out_valid", 32'(dn2.valid), 32'(q2.size() != 0));
      chk("d2_out_data",  dn2.data, (q2.size() != 0) ? q2[0] : 32'h0);
      chk("d2_count",     32'(count2), 32'(q2.size()));
      chk("d2_in_ready",  32'(up2.ready), 32'(q2.size() < 2));
      chk("d3_out_valid", 32'(dn3.valid), 32'(q3.size() != 0));
      chk("d3_out_data",  dn3.data, (q3.size() != 0) ? q3[0] : 32'h0);
      chk("d3_count",     32'(count3), 32'(q3.size()));
      chk("d3_in_ready",  32'(up3.ready), 32'(q3.size() < 3));
`ifdef PIPE_STATS_EN
      chk("d2_stall_cnt", 32'(stall2), 32'(st2));
      chk("d3_stall_cnt", 32'(stall3), 32'(st3));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] hold_vals [4];
    hold_vals[0] = 32'hA; hold_vals[1] = 32'hB;
    hold_vals[2] = 32'hC; hold_vals[3] = 32'hD;

    // Reset then idle
    repeat (3) tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_valid", 32'(dn2.valid), 32'h0);
      chk("idle_data",  dn2.data, 32'h0);
      chk("idle_count", 32'(count3), 32'h0);
      chk("idle_ready", 32'(up3.ready), 32'h1);
    end

    // Back-to-back stream, always-ready downstream
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(i);
      tick();
      chk("stream_valid", 32'(dn2.valid), 32'h1);
      chk("stream_data",  dn2.data, 32'(i));
      chk("stream_ready", 32'(up2.ready), 32'h1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drain", 32'(dn2.valid), 32'h0);

    // Hold downstream, fill DEPTH=3, then drain in order across the wrap
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = hold_vals[k];
      tick();
    end
    chk("full_count", 32'(count3), 32'h3);
    chk("full_ready", 32'(up3.ready), 32'h0);
    in_data = hold_vals[3];
    repeat (2) tick();
    chk("held_count", 32'(count3), 32'h3);
    chk("held_head",  dn3.data, 32'hA);
    out_ready = 1'b1;
    tick();
    chk("drain_b", dn3.data, 32'hB);
    chk("drain_b_cnt", 32'(count3), 32'h2);
    tick();
    in_valid = 1'b0;
    chk("drain_c", dn3.data, 32'hC);
    tick();
    chk("drain_d", dn3.data, 32'hD);
    tick();
    chk("drain_empty", 32'(dn3.valid), 32'h0);
    tick();

    // Flush with a beat on the input
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h11; tick();
    in_data = 32'h22; tick();
    chk("pre_flush_count", 32'(count3), 32'h2);
    in_data = 32'hEE; flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_count", 32'(count3), 32'h0);
    chk("flush_valid", 32'(dn3.valid), 32'h0);
    chk("flush_data",  dn3.data, 32'h0);
    chk("flush_ready", 32'(up3.ready), 32'h1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("flush_no_ee", 32'(dn3.valid), 32'h0);
    end

    // Reset while full
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = 32'h31 + 32'(k); tick();
    end
    chk("prerst_full", 32'(count3), 32'h3);
    in_valid = 1'b0; rst = 1'b1; tick();
    rst = 1'b0;
    chk("rst_count", 32'(count3), 32'h0);
    chk("rst_valid", 32'(dn3.valid), 32'h0);
    chk("rst_data",  dn3.data, 32'h0);
    chk("rst_ready", 32'(up3.ready), 32'h1);
    in_valid = 1'b1; in_data = 32'h55; tick();
    in_valid = 1'b0;
    chk("post_rst_valid", 32'(dn3.valid), 32'h1);
    chk("post_rst_data",  dn3.data, 32'h55);
    chk("post_rst_data2", dn2.data, 32'h55);
    out_ready = 1'b1; tick();

`ifdef PIPE_STATS_EN
    // Stall counter saturation, immune to flush
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h66; tick();
    in_valid = 1'b0;
    repeat (20) tick();
    chk("stall_sat", 32'(stall3), 32'hF);
    flush = 1'b1; tick();
    flush = 1'b0;
    chk("stall_after_flush", 32'(stall3), 32'hF);
    chk("stall_flush_count", 32'(count3), 32'h0);
    out_ready = 1'b1; tick();
`endif

    // Randomized traffic against the models
    for (int i = 0; i < 2000; i++) begin
      in_valid  = ($urandom_range(99) < 70);
      in_data   = $urandom;
      out_ready = ($urandom_range(99) < 60);
      flush     = ($urandom_range(99) < 3);
      rst       = ($urandom_range(99) < 1);
      tick();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_elastic_reg.md
# pipe_elastic_reg

Parametrised elastic pipeline stage register, the successor to the fixed-field ID/EX stage register. The old three-way stall bus (Bubb/Pass/Hold) is replaced by a valid/ready handshake. An opaque payload of configurable width is buffered in a DEPTH-entry queue. A flush input squashes all in-flight entries on branch mispredict. It sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM) and lets upstream keep issuing while downstream is briefly busy.

## Interface
- PAYLOAD_W, 32: payload width in bits; must be ≥1.
- DEPTH, 2: number of buffered entries; must be ≥1. Full throughput requires ≥2.
- CNT_W, 32: width of the stall counter (only when PIPE_STATS_EN is defined).
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  squash all buffered entries; same role as the old branch_error.
- in_valid  in  1  upstream offers in_data.
- in_ready  out  1  stage can accept; a registered function of occupancy only.
- in_data  in  PAYLOAD_W  upstream payload.
- out_valid  out  1  head entry present.
- out_ready  in  1  downstream accepts the head.
- out_data  out  PAYLOAD_W  head payload; all zeros when out_valid=0 (bubble).
- count  out  clog2(DEPTH+1)  current occupancy.
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid && !out_ready (only with PIPE_STATS_EN).

## Operation
- push = in_valid && in_ready && !flush.
- pop = out_valid && out_ready && !flush.
- Storage is a circular queue with rd_ptr and wr_ptr, each in 0..DEPTH-1. On increment, DEPTH-1 wraps to 0 explicitly, so DEPTH need not be a power of two.
- count' = count + push − pop. Push and pop in the same cycle leave count unchanged and advance both pointers.
- in_ready = (count < DEPTH), registered. A full queue refuses input even if out_ready=1 in that cycle; there is no combinational ready path.
- out_data is driven from the entry at rd_ptr when count>0, and forced to 0 otherwise.
- Entries leave strictly in FIFO order. The payload is never modified.
- Flush:
  - count←0 and rd_ptr=wr_ptr←0.
  - The input beat presented in the flush cycle is dropped.
  - The downstream handshake in that cycle does not count as a pop: downstream must treat out_data as squashed.
- Legacy hold behaviour is obtained by driving out_ready=0. Legacy bubble behaviour is obtained by driving in_valid=0.

## Timing
- Reset values: out_valid=0, out_data=0, count=0, in_ready=1 (first cycle after rst deasserts), stall_cnt=0, pointers=0.
- rst has priority over flush, and flush has priority over push/pop.
- Latency: a beat pushed at edge N appears as out_valid=1 and out_data at edge N+1. There is no zero-latency bypass.
- Throughput is 1 beat/cycle when DEPTH≥2 and downstream is always ready. With DEPTH=1 it is 1 beat per 2 cycles.
- in_ready=0 for the cycle after count reaches DEPTH. It returns to 1 the cycle after the first pop or a flush.
- rst asserted mid-operation discards all contents; the outputs take reset values at the next edge.
- in_data is sampled only on push. Upstream must hold in_valid/in_data stable until in_ready is seen.

## Configuration
- PIPE_STATS_EN defined:
  - stall_cnt port and register are present.
  - The counter increments by 1 each cycle with out_valid && !out_ready and saturates at all-ones.
  - It is cleared by rst only, not by flush.
- PIPE_STATS_EN undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- The shared include config.v gains PIPE_DEFAULT_DEPTH and PIPE_DEFAULT_PAYLOAD_W.
- Each stage's payload field-packing widths go into config.v alongside the existing bus defines (InstAddrBus, RegBus, etc.), so stage wrappers pack/unpack consistently.
- One sub-module, pipe_elastic_mem:
  - DEPTH×PAYLOAD_W register array with a write port (wr_en, wr_ptr, data) and an asynchronous read at rd_ptr.
  - No reset on the array itself; zero-output is enforced in pipe_elastic_reg.

## Test plan
- Reset, then idle: out_valid=0, out_data=0, count=0, in_ready=1 for 10 cycles.
- DEPTH=2, PAYLOAD_W=32, out_ready=1, stream 0x1..0x8 back-to-back → out_data 0x1..0x8 on consecutive cycles, each one cycle after its push, with no gaps.
- DEPTH=3, out_ready=0, push 0xA,0xB,0xC,0xD:
  - after three pushes count=3 and in_ready=0;
  - 0xD is held upstream;
  - set out_ready=1 → outputs A,B,C,D in order; pointer wrap is exercised.
- Queue holding 2 entries, assert flush with in_valid=1 (0xEE) → next cycle count=0, out_valid=0, out_data=0, in_ready=1, and 0xEE never appears.
- Full queue, rst pulsed for 1 cycle → all outputs at reset values next edge; the subsequent push 0x55 emerges after 1 cycle.
- With PIPE_STATS_EN and CNT_W=4, hold out_valid=1 with out_ready=0 for 20 cycles → stall_cnt saturates at 0xF. A flush leaves stall_cnt at 0xF.
